// File: rtl/sdram_rd_arbiter.sv
// sdram_rd_arbiter: shares one 8-bit SDRAM read port between two level-request ports (round-robin).
// Optional macro ARB_FIXED_PRIO_EN: port 0 always wins ties instead of round-robin.
module sdram_rd_arbiter #(
    parameter int AW     = 25,
    parameter int RD_LAT = 2
) (
    input  logic          i_clk,
    input  logic          i_reset,
    input  logic          i_req0,
    input  logic [AW-1:0] i_addr0,
    output logic          o_ack0,
    output logic [7:0]    o_data0,
    input  logic          i_req1,
    input  logic [AW-1:0] i_addr1,
    output logic          o_ack1,
    output logic [7:0]    o_data1,
    output logic [AW-1:0] o_sdram_addr,
    output logic          o_sdram_rd,
    input  logic [7:0]    i_sdram_data,
    output logic          o_busy
);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(RD_LAT - 1);

    state_t     r_state;
    logic       r_grant;
    logic [3:0] r_lat_cnt;
    logic       w_pick1;

`ifdef ARB_FIXED_PRIO_EN
    assign w_pick1 = ~i_req0;
`else
    logic r_last_grant;

    // On a tie the port that was not served last wins; otherwise the lone requester wins.
    assign w_pick1 = (i_req0 && i_req1) ? ~r_last_grant : i_req1;
`endif

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= S_IDLE;
            r_grant      <= 1'b0;
            r_lat_cnt    <= '0;
            o_sdram_rd   <= 1'b0;
            o_sdram_addr <= '0;
            o_ack0       <= 1'b0;
            o_ack1       <= 1'b0;
            o_data0      <= '0;
            o_data1      <= '0;
            o_busy       <= 1'b0;
`ifndef ARB_FIXED_PRIO_EN
            r_last_grant <= 1'b1;
`endif
        end else begin
            o_ack0 <= 1'b0;
            o_ack1 <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_req0 || i_req1) begin
                        r_grant      <= w_pick1;
                        o_sdram_addr <= w_pick1 ? i_addr1 : i_addr0;
                        o_sdram_rd   <= 1'b1;
                        o_busy       <= 1'b1;
                        r_state      <= S_ISSUE;
`ifndef ARB_FIXED_PRIO_EN
                        r_last_grant <= w_pick1;
`endif
                    end
                end
                S_ISSUE: begin
                    o_sdram_rd <= 1'b0;
                    r_lat_cnt  <= LAT_LOAD;
                    r_state    <= S_WAIT;
                end
                S_WAIT: begin
                    if (r_lat_cnt == 4'd0) begin
                        // Data and ack land on the same edge so the ack cycle carries valid data.
                        if (r_grant) begin
                            o_data1 <= i_sdram_data;
                            o_ack1  <= 1'b1;
                        end else begin
                            o_data0 <= i_sdram_data;
                            o_ack0  <= 1'b1;
                        end
                        r_state <= S_DONE;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end
                S_DONE: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    o_sdram_rd <= 1'b0;
                    o_busy     <= 1'b0;
                    r_state    <= S_IDLE;
                end
            endcase
        end
    end

endmodule
